// File: rtl/uart_rx.sv
// UART receiver: start / DATA_BITS data (LSB first) / optional even-XOR parity / one stop.
// Received words are offered on a valid/ready handshake with per-word error flags.
module uart_rx #(
    parameter int BAUD_DIV      = 434,
    parameter int DATA_BITS     = 8,
    parameter int ENABLE_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic                   sync1, rxs, rxs_q;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   perr;
    logic                   fall, tick, done;

    // Synchronizer and edge flop reset high so a line idling high never looks like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_q <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxs_q <= rxs;
        end
    end

    assign fall = rxs_q & ~rxs;
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (fall) state_nxt = START;
            START: begin
                tick = (cnt == HALF);
                if (tick) state_nxt = rxs ? IDLE : DATA;
            end
            DATA: begin
                tick = (cnt == FULL);
                if (tick && idx == LAST) state_nxt = (ENABLE_PARITY != 0) ? PARITY : STOP;
            end
            PARITY: begin
                tick = (cnt == FULL);
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                tick = (cnt == FULL);
                if (tick) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (tick || state == IDLE) ? '0 : cnt + CW'(1);
            if (state == IDLE) begin
                idx  <= '0;
                perr <= 1'b0;
            end
            if (state == DATA && tick) begin
                shift[idx] <= rxs;
                idx        <= idx + IW'(1);
            end
            if (state == PARITY && tick) perr <= rxs ^ (^shift);
        end
    end

    // A completing frame wins over the handshake; an unaccepted word is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data_out   <= shift;
                    parity_err <= perr;
                    frame_err  <= ~rxs;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance with parity, one without, BAUD_DIV=16.
module tb_uart_rx;

    localparam int BAUD = 16;

    logic       clk, rst_n;
    logic       rx1, ready1, v1, pe1, fe1, ov1, busy1;
    logic [7:0] d1;
    logic       rx0, ready0, v0, pe0, fe0, ov0, busy0;
    logic [7:0] d0;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int ov_base;

    uart_rx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .ENABLE_PARITY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .ready(ready1), .data_out(d1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1)
    );

    uart_rx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .ENABLE_PARITY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .ready(ready0), .data_out(d0), .valid(v0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (ov1 === 1'b1) ov_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input bit which, input logic b);
        if (which) rx1 = b;
        else       rx0 = b;
        repeat (BAUD) @(negedge clk);
    endtask

    // Parity bit is only sent to the parity-enabled instance.
    task automatic send(input bit which, input logic [7:0] d, input logic par, input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which) drive_bit(which, par);
        drive_bit(which, stop);
    endtask

    task automatic accept1;
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        chk("accept_valid_clear", v1, 0);
    endtask

    initial begin
        rst_n = 1'b0; rx1 = 1'b1; rx0 = 1'b1; ready1 = 1'b0; ready0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", d1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_flags", {pe1, fe1, ov1, busy1}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5, correct parity 0
        send(1, 8'hA5, 1'b0, 1'b1);
        chk("a5_valid", v1, 1);
        chk("a5_data", d1, 8'hA5);
        chk("a5_flags", {pe1, fe1}, 0);
        repeat (5) @(negedge clk);
        chk("a5_hold_valid", v1, 1);
        accept1();

        // 0x3C with wrong parity bit
        send(1, 8'h3C, 1'b1, 1'b1);
        chk("3c_data", d1, 8'h3C);
        chk("3c_perr", pe1, 1);
        chk("3c_ferr", fe1, 0);
        accept1();

        // 0x3C without parity
        send(0, 8'h3C, 1'b0, 1'b1);
        chk("np_valid", v0, 1);
        chk("np_data", d0, 8'h3C);
        chk("np_flags", {pe0, fe0}, 0);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        chk("np_accept", v0, 0);

        // 5-cycle glitch: false start
        rx1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", busy1, 1);
        @(negedge clk);
        rx1 = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_idle", busy1, 0);
        chk("glitch_novalid", v1, 0);

        // 0x55 with stop bit low, then break
        send(1, 8'h55, 1'b0, 1'b0);
        chk("brk_valid", v1, 1);
        chk("brk_data", d1, 8'h55);
        chk("brk_ferr", fe1, 1);
        chk("brk_perr", pe1, 0);
        accept1();
        repeat (30 * BAUD) @(negedge clk);
        chk("brk_no_more", v1, 0);
        chk("brk_not_busy", busy1, 0);
        rx1 = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        send(1, 8'hA5, 1'b0, 1'b1);
        chk("brk_recover_data", d1, 8'hA5);
        chk("brk_recover_flags", {v1, pe1, fe1}, 3'b100);
        accept1();

        // back-to-back with ready low: second frame dropped
        ov_base = ov_cnt;
        send(1, 8'h11, 1'b0, 1'b1);
        chk("b2b_first", d1, 8'h11);
        send(1, 8'h22, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("ovr_pulses", ov_cnt - ov_base, 1);
        chk("ovr_keep_data", d1, 8'h11);
        chk("ovr_keep_valid", v1, 1);

        // ready exactly in the completion cycle: new word replaces old, valid stays up
        ov_base = ov_cnt;
        fork
            send(1, 8'h22, 1'b0, 1'b1);
            begin
                repeat (170) @(negedge clk);
                chk("edge_before", {v1, d1}, {1'b1, 8'h11});
                ready1 = 1'b1;
                @(negedge clk);
                ready1 = 1'b0;
                chk("edge_after", {v1, d1}, {1'b1, 8'h22});
            end
        join
        chk("edge_no_ovr", ov_cnt - ov_base, 0);

        // reset in the middle of data bit 4
        drive_bit(1, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1, 1'b0);
        rx1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_busy", busy1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", d1, 0);
        chk("mid_rst_flags", {v1, pe1, fe1, ov1, busy1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (BAUD) @(negedge clk);
        chk("post_rst_idle", {v1, busy1}, 0);
        send(1, 8'hF0, 1'b0, 1'b1);
        chk("f0_data", d1, 8'hF0);
        chk("f0_flags", {v1, pe1, fe1}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
